mc_seq: RTL
===========

Name: mc_seq

Overview:
- Multicycle sequencer for the next-generation core.
- Replaces the single-cycle shared-port arrangement, where instruction and data accesses are multiplexed onto one zero-latency memory within a cycle.
- Owns PC, IR and MDR. Sequences fetch, execute, memory and writeback over one shared memory port with a variable-latency req/ready handshake.
- Sits between ctrl/decode, alu, regfile and mem. Raises a sticky trap on illegal, misaligned or timed-out accesses.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 0, PC value after reset.
- MAX_WAIT, 0, max cycles waiting for mem_ready before timeout trap; 0 disables the check.
- ALIGN_CHECK, 1, 1 enables misalignment traps; 0 passes addresses through unchecked.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req  out  1  memory request valid
- mem_wen  out  1  store when high (qualified by mem_req)
- mem_mode  out  3  access size/sign, same encoding as mem sel (bits[1:0]: 0 byte, 1 half, 2 word)
- mem_addr  out  XLEN  access address
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  read data, valid when mem_ready
- mem_ready  in  1  transfer completes on req&ready
- ir  out  32  current instruction, to ctrl/decode
- pc  out  XLEN  current PC
- mdr  out  XLEN  latched load data, to writeback mux
- dec_load  in  1  decoded load
- dec_store  in  1  decoded store
- dec_illegal  in  1  decode error
- dec_mode  in  3  data access mode
- dec_rd_wen  in  1  instruction writes rd
- alu_res  in  XLEN  effective address / result
- store_data  in  XLEN  regB value
- next_pc  in  XLEN  branch/jump target or pc+4, from branch unit
- reg_wen  out  1  regfile write strobe
- wb_sel  out  1  1 selects mdr, 0 selects alu_res
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky error flag
- trap_cause  out  2  0 illegal, 1 fetch misaligned, 2 data misaligned, 3 bus timeout

Behaviour:
- States: FETCH, EXEC, MEM, WB, TRAP.
- Reset (rst high at a clk edge), applied in any state including mid-transaction:
  - State: FETCH.
  - Registers: pc=RESET_PC, ir=32'h00000013 (NOP), mdr=0, wait counter=0.
  - Outputs low: mem_req, mem_wen, reg_wen, retire, trap; trap_cause=0.
  - An abandoned in-flight request is dropped; mem_req is low the cycle after the reset edge.
- FETCH:
  - If ALIGN_CHECK and pc[1:0]!=0: go to TRAP with cause 1, no request.
  - Otherwise drive mem_req=1, mem_wen=0, mode=word, mem_addr=pc.
  - On req&ready: ir<=mem_rdata, go to EXEC.
- EXEC (always 1 cycle, no request):
  - dec_illegal → TRAP with cause 0.
  - dec_load or dec_store → MEM if the address is aligned; misaligned with ALIGN_CHECK → TRAP with cause 2. Half needs addr[0]=0; word needs addr[1:0]=0.
  - Otherwise → WB.
- MEM:
  - Drive mem_req=1, mem_addr=alu_res, mem_mode=dec_mode, mem_wen=dec_store, mem_wdata=store_data.
  - On req&ready: a load latches mdr<=mem_rdata; go to WB.
- WB (1 cycle):
  - reg_wen=dec_rd_wen & !dec_store; wb_sel=dec_load.
  - pc<=next_pc; retire=1; go to FETCH.
- Handshake rules:
  - While mem_req is high and ready is low, mem_addr/wen/wdata/mode stay stable and req stays high.
  - mem_ready with mem_req low is ignored.
  - Zero-wait memory (ready tied high): FETCH and MEM each take 1 cycle. Minimum CPI is 3 for ALU ops and 4 for loads/stores.
- Timeout:
  - Wait counter increments each cycle req&!ready and clears on completion or state change.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT while still waiting: go to TRAP with cause 3 and drop req the next cycle.
- TRAP:
  - trap=1 and trap_cause held.
  - No requests, pc/ir frozen, reg_wen=0.
  - Exit only via rst.
- Registered outputs: pc, ir, mdr, trap, trap_cause.
- Decoded outputs of state: mem_req, mem_wen, reg_wen, retire, wb_sel.
- Arithmetic: pc is not incremented internally; next_pc is authoritative. XLEN-wide values wrap naturally.

Decomposition:
- Package mc_pkg:
  - state enum mc_state_t {FETCH, EXEC, MEM, WB, TRAP}.
  - trap cause enum.
  - mem_mode size constants (MODE_B/H/W).
  - NOP encoding constant.
- Sub-module mc_align_chk: combinational (addr[1:0], mode) → misaligned flag; used for both fetch and data checks.
- Sequencer FSM and registers stay in mc_seq.

Test Plan:
- ALU op, ready tied high:
  - Stimulus: mem_rdata=32'h00500093, next_pc=4, dec_rd_wen=1.
  - Required: req in cycle 0; EXEC cycle 1; WB cycle 2 with reg_wen=1, wb_sel=0, retire=1; pc=4 in cycle 3.
- Load with ready delayed 3 cycles:
  - Stimulus: alu_res=32'h100, dec_mode=word, mem_rdata=32'hDEADBEEF on ready.
  - Required: addr/mode stable during the wait; mdr=32'hDEADBEEF; wb_sel=1, reg_wen=1 in WB.
- Store:
  - Stimulus: store_data=32'hCAFE0001, addr 8.
  - Required: mem_wen=1 only during MEM; reg_wen=0 in WB; retire=1.
- Misaligned:
  - Stimulus: word load with alu_res=32'h102.
  - Required: TRAP, cause 2, no data request.
  - Stimulus: next_pc=6.
  - Required: cause 1 on the next FETCH, no request.
- Timeout:
  - Stimulus: MAX_WAIT=4, ready held low.
  - Required: trap=1, cause 3 after 4 wait cycles; req low thereafter.
  - Stimulus: dec_illegal.
  - Required: cause 0.
- Reset mid-MEM:
  - Stimulus: rst pulsed while req high.
  - Required: next cycle req=0, pc=RESET_PC, ir=NOP, trap=0; fetch restarts.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    TRAP  = 3'd4
  } mc_state_t;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL   = 2'd0,
    CAUSE_FETCH_MIS = 2'd1,
    CAUSE_DATA_MIS  = 2'd2,
    CAUSE_TIMEOUT   = 2'd3
  } mc_cause_t;

  // Access size field, bits [1:0] of the mem mode encoding
  localparam logic [1:0] MODE_B = 2'd0;
  localparam logic [1:0] MODE_H = 2'd1;
  localparam logic [1:0] MODE_W = 2'd2;

  // Full 3-bit mode used for instruction fetch (unsigned word)
  localparam logic [2:0] MODE_FETCH = {1'b0, MODE_W};

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mc_align_chk.sv
// Access alignment checker: flags an address whose low bits do not
// match the natural alignment of the access size.
module mc_align_chk
  import mc_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  logic [1:0] i_size,
  output logic       o_misaligned
);

  // Bytes are always aligned; halves need bit 0 clear; word (and the
  // reserved size code) need both low bits clear.
  always_comb begin
    o_misaligned = 1'b0;
    case (i_size)
      MODE_B:  o_misaligned = 1'b0;
      MODE_H:  o_misaligned = i_addr_lo[0];
      default: o_misaligned = |i_addr_lo;
    endcase
  end

endmodule

// File: rtl/mc_seq.sv
// Multicycle sequencer: owns PC, IR and MDR and walks each instruction
// through fetch, execute, memory and writeback over one shared memory
// port with a variable-latency req/ready handshake. Faults park the
// machine in a sticky trap state that only reset clears.
module mc_seq
  import mc_pkg::*;
#(
  parameter int unsigned          XLEN        = 32,
  parameter logic [XLEN-1:0]      RESET_PC    = '0,
  parameter int unsigned          MAX_WAIT    = 0,
  parameter bit                   ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_wen,
  output logic [2:0]      mem_mode,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] mdr,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_illegal,
  input  logic [2:0]      dec_mode,
  input  logic            dec_rd_wen,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] next_pc,
  output logic            reg_wen,
  output logic            wb_sel,
  output logic            retire,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  mc_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_mdr;
  logic [31:0]     r_wait;
  logic            r_idle;
  logic            r_trap;
  mc_cause_t       r_cause;

  logic w_fetch_mis_raw;
  logic w_data_mis_raw;
  logic w_fetch_mis;
  logic w_data_mis;
  logic w_timeout;

  mc_align_chk u_fetch_chk (
    .i_addr_lo    (r_pc[1:0]),
    .i_size       (MODE_W),
    .o_misaligned (w_fetch_mis_raw)
  );

  mc_align_chk u_data_chk (
    .i_addr_lo    (alu_res[1:0]),
    .i_size       (dec_mode[1:0]),
    .o_misaligned (w_data_mis_raw)
  );

  assign w_fetch_mis = ALIGN_CHECK && w_fetch_mis_raw;
  assign w_data_mis  = ALIGN_CHECK && w_data_mis_raw;

  // Fires on the last tolerated stalled cycle so req drops right after.
  assign w_timeout = (MAX_WAIT != 0) && mem_req && !mem_ready &&
                     (r_wait == 32'(MAX_WAIT - 1));

  assign pc         = r_pc;
  assign ir         = r_ir;
  assign mdr        = r_mdr;
  assign trap       = r_trap;
  assign trap_cause = r_cause;

  // Port strobes decoded from the current state; r_idle keeps req low for
  // the first cycle after reset so an abandoned transfer is not re-issued
  // back-to-back with the reset edge.
  always_comb begin
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_mode  = MODE_FETCH;
    mem_addr  = r_pc;
    mem_wdata = store_data;
    reg_wen   = 1'b0;
    wb_sel    = 1'b0;
    retire    = 1'b0;
    case (r_state)
      FETCH: mem_req = !r_idle && !w_fetch_mis;
      MEM: begin
        mem_req  = 1'b1;
        mem_wen  = dec_store;
        mem_mode = dec_mode;
        mem_addr = alu_res;
      end
      WB: begin
        reg_wen = dec_rd_wen & ~dec_store;
        wb_sel  = dec_load;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, architectural registers, wait counter and trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= NOP_INSN;
      r_mdr   <= '0;
      r_wait  <= '0;
      r_idle  <= 1'b1;
      r_trap  <= 1'b0;
      r_cause <= CAUSE_ILLEGAL;
    end else begin
      r_idle <= 1'b0;
      case (r_state)
        FETCH: begin
          if (!r_idle) begin
            if (w_fetch_mis) begin
              r_state <= TRAP;
              r_trap  <= 1'b1;
              r_cause <= CAUSE_FETCH_MIS;
            end else if (mem_ready) begin
              r_ir    <= mem_rdata[31:0];
              r_wait  <= '0;
              r_state <= EXEC;
            end else if (w_timeout) begin
              r_wait  <= '0;
              r_state <= TRAP;
              r_trap  <= 1'b1;
              r_cause <= CAUSE_TIMEOUT;
            end else begin
              r_wait <= r_wait + 32'd1;
            end
          end
        end
        EXEC: begin
          r_wait <= '0;
          if (dec_illegal) begin
            r_state <= TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_ILLEGAL;
          end else if (dec_load || dec_store) begin
            if (w_data_mis) begin
              r_state <= TRAP;
              r_trap  <= 1'b1;
              r_cause <= CAUSE_DATA_MIS;
            end else begin
              r_state <= MEM;
            end
          end else begin
            r_state <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (dec_load) r_mdr <= mem_rdata;
            r_wait  <= '0;
            r_state <= WB;
          end else if (w_timeout) begin
            r_wait  <= '0;
            r_state <= TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        WB: begin
          r_pc    <= next_pc;
          r_state <= FETCH;
        end
        TRAP: ;
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
